// File: rtl/buffer_line_pkg.sv
// Shared types and default widths for the buffer line arbiter and its interface.
package buffer_line_pkg;

  localparam int DEFAULT_NUM_PORTS  = 4;
  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/buffer_line_interface.sv
// One buffer line: a producer offers addr/data with valids, the consumer answers with ack.
interface buffer_line_interface
  import buffer_line_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  // Handshake: a transfer is offered while addr_valid or data_valid is high and
  // completes on a rising edge where ack is also high; the producer may withdraw
  // both valids before ack, which cancels the offer without completing it.
  logic [ADDR_WIDTH-1:0] addr;
  logic                  addr_valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  data_valid;
  logic                  data_just_matched;
  logic                  ack;

  modport producer (
    output addr, addr_valid, data, data_valid, data_just_matched,
    input  ack
  );

  modport consumer (
    input  addr, addr_valid, data, data_valid, data_just_matched,
    output ack
  );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i, cyclically.
module rr_priority_picker #(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]         req_i,
  input  logic [$clog2(NUM_PORTS)-1:0] rr_ptr_i,
  output logic [$clog2(NUM_PORTS)-1:0] winner_o,
  output logic                         any_valid_o
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester is written last.
  always_comb begin
    winner_o    = '0;
    any_valid_o = 1'b0;
    cand        = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr_i) + k) % NUM_PORTS);
      if (req_i[cand]) begin
        winner_o    = cand;
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/buffer_line_arbiter.sv
// Round-robin arbiter granting one upstream requester at a time onto a shared buffer line.
module buffer_line_arbiter
  import buffer_line_pkg::*;
#(
  parameter int NUM_PORTS  = DEFAULT_NUM_PORTS,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  buffer_line_interface.consumer       req [NUM_PORTS],
  buffer_line_interface.producer       line,
  output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
  output logic                         busy
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_PORTS-1:0]  av_vec, dv_vec, djm_vec, req_vec, ack_vec;
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_PORTS];
  logic [DATA_WIDTH-1:0] data_arr [NUM_PORTS];

  logic [IDX_W-1:0]      winner;
  logic                  any_valid;
  logic                  line_ack;
  logic [IDX_W-1:0]      next_ptr;

  logic [ADDR_WIDTH-1:0] line_addr;
  logic [DATA_WIDTH-1:0] line_data;
  logic                  line_av, line_dv, line_djm;

  // Interface arrays only take constant indices, so flatten them here.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign av_vec[g]   = req[g].addr_valid;
    assign dv_vec[g]   = req[g].data_valid;
    assign djm_vec[g]  = req[g].data_just_matched;
    assign addr_arr[g] = req[g].addr;
    assign data_arr[g] = req[g].data;
    assign req[g].ack  = ack_vec[g];
  end

  assign req_vec  = av_vec | dv_vec;
  assign line_ack = line.ack;
  assign next_ptr = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

  rr_priority_picker #(
    .NUM_PORTS (NUM_PORTS)
  ) u_picker (
    .req_i       (req_vec),
    .rr_ptr_i    (rr_ptr_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Completion and abort both release the line and move the pointer past the owner.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d = GRANTED;
          grant_d = winner;
        end
      end
      GRANTED: begin
        if (line_ack || !req_vec[grant_q]) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    line_addr = '0;
    line_data = '0;
    line_av   = 1'b0;
    line_dv   = 1'b0;
    line_djm  = 1'b0;
    ack_vec   = '0;
    if (state_q == GRANTED) begin
      busy             = 1'b1;
      line_addr        = addr_arr[grant_q];
      line_data        = data_arr[grant_q];
      line_av          = av_vec[grant_q];
      line_dv          = dv_vec[grant_q];
      line_djm         = djm_vec[grant_q];
      ack_vec[grant_q] = line_ack;
    end
  end

  assign line.addr              = line_addr;
  assign line.data              = line_data;
  assign line.addr_valid        = line_av;
  assign line.data_valid        = line_dv;
  assign line.data_just_matched = line_djm;
  assign grant_idx              = grant_q;

endmodule

// File: tb/tb_buffer_line_arbiter.sv
// Directed table-driven bench for buffer_line_arbiter with a round-robin order scoreboard.
module tb_buffer_line_arbiter;

  localparam int NP = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  typedef struct packed {
    logic          rst;
    logic [NP-1:0] av;
    logic [NP-1:0] dv;
    logic [NP-1:0] djm;
    logic          lack;
    logic          e_busy;
    logic [1:0]    e_gidx;
    logic          e_lav;
    logic          e_ldv;
    logic          e_ldjm;
    logic [AW-1:0] e_laddr;
    logic [DW-1:0] e_ldata;
    logic [NP-1:0] e_ack;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT hookup ----------------
  logic [NP-1:0] r_av, r_dv, r_djm;
  logic [AW-1:0] r_addr [NP];
  logic [DW-1:0] r_data [NP];
  logic          r_lack;
  logic [NP-1:0] ack_obs;
  logic [1:0]    grant_idx;
  logic          busy;

  buffer_line_interface #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) req_if [NP] ();
  buffer_line_interface #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) line_if ();

  for (genvar g = 0; g < NP; g++) begin : g_drv
    assign req_if[g].addr              = r_addr[g];
    assign req_if[g].data              = r_data[g];
    assign req_if[g].addr_valid        = r_av[g];
    assign req_if[g].data_valid        = r_dv[g];
    assign req_if[g].data_just_matched = r_djm[g];
    assign ack_obs[g]                  = req_if[g].ack;
  end
  assign line_if.ack = r_lack;

  buffer_line_arbiter #(
    .NUM_PORTS  (NP),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req_if),
    .line      (line_if),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [1:0] exp_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic logic [63:0] line_obs();
    return 64'({line_if.addr_valid, line_if.data_valid, line_if.data_just_matched,
                line_if.addr, line_if.data});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic add(input logic rst, input logic [3:0] av, input logic [3:0] dv,
                     input logic [3:0] djm, input logic lack, input logic e_busy,
                     input logic [1:0] e_gidx, input logic e_lav, input logic e_ldv,
                     input logic e_ldjm, input logic [7:0] e_laddr,
                     input logic [31:0] e_ldata, input logic [3:0] e_ack);
    vecs.push_back('{rst, av, dv, djm, lack, e_busy, e_gidx, e_lav, e_ldv, e_ldjm,
                     e_laddr, e_ldata, e_ack});
  endtask

  task automatic apply(input logic rst, input logic [3:0] av, input logic [3:0] dv,
                       input logic [3:0] djm, input logic lack);
    reset  = rst;
    r_av   = av;
    r_dv   = dv;
    r_djm  = djm;
    r_lack = lack;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] e;
    r_addr[0] = 8'h10; r_addr[1] = 8'h11; r_addr[2] = 8'h15; r_addr[3] = 8'h13;
    for (int i = 0; i < NP; i++) r_data[i] = 32'hCAFE_0000 + 32'(i);

    //     rst av       dv       djm      lk  bsy g  av dv dj addr   data           ack
    add(0, 4'b0100, 4'b0000, 4'b0000, 0,  0, 0, 0, 0, 0, 8'h00, 32'h0,         4'b0000); // t0
    add(0, 4'b0100, 4'b0000, 4'b0000, 0,  1, 2, 1, 0, 0, 8'h15, 32'hCAFE_0002, 4'b0000);
    add(0, 4'b1110, 4'b0000, 4'b0000, 0,  1, 2, 1, 0, 0, 8'h15, 32'hCAFE_0002, 4'b0000);
    add(0, 4'b0100, 4'b0000, 4'b0000, 1,  1, 2, 1, 0, 0, 8'h15, 32'hCAFE_0002, 4'b0100);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0,  0, 0, 0, 0, 0, 8'h00, 32'h0,         4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0010, 1,  0, 0, 0, 0, 0, 8'h00, 32'h0,         4'b0000); // t5
    add(0, 4'b1001, 4'b0000, 4'b0000, 0,  0, 0, 0, 0, 0, 8'h00, 32'h0,         4'b0000);
    add(0, 4'b1001, 4'b0000, 4'b0000, 1,  1, 3, 1, 0, 0, 8'h13, 32'hCAFE_0003, 4'b1000);
    add(0, 4'b1001, 4'b0000, 4'b0000, 0,  0, 0, 0, 0, 0, 8'h00, 32'h0,         4'b0000);
    add(0, 4'b1001, 4'b0000, 4'b0000, 1,  1, 0, 1, 0, 0, 8'h10, 32'hCAFE_0000, 4'b0001);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0,  0, 0, 0, 0, 0, 8'h00, 32'h0,         4'b0000); // t10
    add(0, 4'b0000, 4'b0010, 4'b0010, 1,  0, 0, 0, 0, 0, 8'h00, 32'h0,         4'b0000);
    add(0, 4'b0000, 4'b0010, 4'b0010, 0,  1, 1, 0, 1, 1, 8'h11, 32'hCAFE_0001, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0,  1, 1, 0, 0, 0, 8'h11, 32'hCAFE_0001, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0,  0, 0, 0, 0, 0, 8'h00, 32'h0,         4'b0000);
    add(0, 4'b0110, 4'b0000, 4'b0000, 0,  0, 0, 0, 0, 0, 8'h00, 32'h0,         4'b0000); // t15
    add(0, 4'b0110, 4'b0000, 4'b0000, 1,  1, 2, 1, 0, 0, 8'h15, 32'hCAFE_0002, 4'b0100);
    add(0, 4'b0110, 4'b0000, 4'b0000, 0,  0, 0, 0, 0, 0, 8'h00, 32'h0,         4'b0000);
    add(0, 4'b0110, 4'b0000, 4'b0000, 1,  1, 1, 1, 0, 0, 8'h11, 32'hCAFE_0001, 4'b0010);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0,  0, 0, 0, 0, 0, 8'h00, 32'h0,         4'b0000);
    add(0, 4'b1000, 4'b0000, 4'b0000, 0,  0, 0, 0, 0, 0, 8'h00, 32'h0,         4'b0000); // t20
    add(1, 4'b1000, 4'b0000, 4'b0000, 1,  1, 3, 1, 0, 0, 8'h13, 32'hCAFE_0003, 4'b1000);
    add(0, 4'b0000, 4'b0000, 4'b0000, 1,  0, 0, 0, 0, 0, 8'h00, 32'h0,         4'b0000);
    add(0, 4'b1010, 4'b0000, 4'b0000, 0,  0, 0, 0, 0, 0, 8'h00, 32'h0,         4'b0000);
    add(0, 4'b1010, 4'b0000, 4'b0000, 1,  1, 1, 1, 0, 0, 8'h11, 32'hCAFE_0001, 4'b0010);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0,  0, 0, 0, 0, 0, 8'h00, 32'h0,         4'b0000); // t25

    // Reset with every input active: outputs must already be quiet.
    apply(1, 4'b1111, 4'b1111, 4'b1111, 1);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("reset_state", 0, 64'({busy, grant_idx}), 64'(0));
    check("reset_line",  0, line_obs(), 64'(0));
    check("reset_ack",   0, 64'(ack_obs), 64'(0));

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      apply(vecs[i].rst, vecs[i].av, vecs[i].dv, vecs[i].djm, vecs[i].lack);
      @(negedge clk);
      check("vec_state", i, 64'({busy, grant_idx}), 64'({vecs[i].e_busy, vecs[i].e_gidx}));
      check("vec_line", i, line_obs(),
            64'({vecs[i].e_lav, vecs[i].e_ldv, vecs[i].e_ldjm, vecs[i].e_laddr,
                 vecs[i].e_ldata}));
      check("vec_ack", i, 64'(ack_obs), 64'(vecs[i].e_ack));
    end

    // Ports 0,1,3 request continuously, each grant acked in its first cycle.
    exp_q = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    @(posedge clk); #1;
    apply(1, 4'b0000, 4'b0000, 4'b0000, 0);
    @(posedge clk); #1;
    apply(0, 4'b1011, 4'b0000, 4'b0000, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_idle_gap", k, 64'(busy), 64'(0));
      @(posedge clk); #1;
      r_lack = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      check("rr_order", k, 64'({busy, grant_idx}), 64'({1'b1, e}));
      check("rr_ack", k, 64'(ack_obs), 64'(4'b0001 << e));
      @(posedge clk); #1;
      r_lack = 1'b0;
    end

    apply(0, 4'b0000, 4'b0000, 4'b0000, 0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
